// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loadable PW-bit serial pattern detector (Mealy).
// The input stream is qualified by en. Matching can overlap or restart after
// each hit. w is combinational and asserts in the same cycle as the last
// pattern bit.
// Optional feature macro: SEQ_DETECT_MATCH_CNT_EN adds a saturating CW-bit
// match counter. Without it, cnt is a constant 0.
module seq_detect_param #(
   parameter int PW = 5,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          j,
   input  logic          pat_ld,
   input  logic [PW-1:0] pat_in,
   input  logic          overlap,
   output logic          w,
   output logic          armed,
   output logic [CW-1:0] cnt
);

   localparam int FW = (PW > 2) ? $clog2(PW) : 1;
   localparam logic [FW-1:0] FMAX = FW'(PW - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state;
   logic [PW-1:0] pat;
   logic [PW-2:0] hist;
   logic [FW-1:0] fill;
   logic [PW-1:0] cand;
   logic          shift;

   // Candidate window: stored history with the incoming bit appended as LSB.
   assign cand  = {hist, j};
   // A qualified bit is consumed only in RUN. A load in the same cycle wins.
   assign shift = (state == RUN) && !pat_ld && en;
   // Mealy match: the window is full and equals the loaded pattern.
   assign w     = shift && (fill == FMAX) && (cand == pat);

   // Control FSM and history shift register. A load restarts the history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         armed <= 1'b0;
         pat   <= '0;
         hist  <= '0;
         fill  <= '0;
      end else if (pat_ld) begin
         state <= RUN;
         armed <= 1'b1;
         pat   <= pat_in;
         hist  <= '0;
         fill  <= '0;
      end else if (shift) begin
         if (w && !overlap) begin
            // Non-overlapping: the next match needs PW fresh bits.
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= cand[PW-2:0];
            fill <= (fill == FMAX) ? FMAX : fill + 1'b1;
         end
      end
   end

`ifdef SEQ_DETECT_MATCH_CNT_EN
   // Saturating match counter, cleared on every pattern load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (pat_ld)
         cnt <= '0;
      else if (w && (cnt != {CW{1'b1}}))
         cnt <= cnt + 1'b1;
   end
`else
   assign cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios with literal
// expectations, then randomized traffic checked each cycle against a
// queue-based model of the detector.
module tb_seq_detect_param;
   localparam int PW = 5;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, en, j, pat_ld, overlap;
   logic [PW-1:0] pat_in;
   logic          w, armed;
   logic [CW-1:0] cnt;

   int ncmp = 0;
   int nerr = 0;

   seq_detect_param #(.PW(PW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .j(j), .pat_ld(pat_ld),
      .pat_in(pat_in), .overlap(overlap), .w(w), .armed(armed), .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit            m_run;
   logic [PW-1:0] m_pat;
   bit            q[$];      // qualified bits since the last restart, oldest first
   int            m_cnt;

   // A match means: the last PW-1 remembered bits followed by j spell the pattern.
   function automatic bit exp_w();
      int sz;
      if (!rst || !m_run || pat_ld || !en) return 1'b0;
      sz = q.size();
      if (sz < PW - 1) return 1'b0;
      for (int k = 0; k < PW - 1; k++)
         if (m_pat[PW-1-k] != q[sz-(PW-1)+k]) return 1'b0;
      return m_pat[0] == j;
   endfunction

   function automatic int exp_cnt();
`ifdef SEQ_DETECT_MATCH_CNT_EN
      return rst ? m_cnt : 0;
`else
      return 0;
`endif
   endfunction

   // Advance the model at each rising edge from the inputs of that cycle.
   always @(posedge clk) begin
      bit hit;
      if (!rst) begin
         m_run = 0; m_pat = '0; q.delete(); m_cnt = 0;
      end else if (pat_ld) begin
         m_run = 1; m_pat = pat_in; q.delete(); m_cnt = 0;
      end else if (m_run && en) begin
         hit = exp_w();
         if (hit && m_cnt < CMAX) m_cnt++;
         if (hit && !overlap) q.delete();
         else begin
            q.push_back(j);
            if (q.size() > PW - 1) void'(q.pop_front());
         end
      end
   end

   // Compare DUT outputs with the model every cycle, away from the clock edge.
   always @(negedge clk) begin
      chk("cyc_w", {31'd0, w}, {31'd0, exp_w()});
      chk("cyc_armed", {31'd0, armed}, {31'd0, (rst && m_run)});
      chk("cyc_cnt", {30'd0, cnt}, exp_cnt());
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic e, input logic jj, input logic ld,
                       input logic [PW-1:0] p, output logic wo);
      en = e; j = jj; pat_ld = ld; pat_in = p;
      @(negedge clk);
      wo = w;
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [PW-1:0] p);
      logic d;
      step(1'b0, 1'b0, 1'b1, p, d);
   endtask

   task automatic stream(input logic [7:0] bits, input int n, output logic [7:0] wv);
      logic d;
      wv = '0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, bits[n-1-i], 1'b0, '0, d);
         wv[i] = d;
      end
   endtask

   initial begin
      logic [7:0] wv;
      logic       d, bub;
      rst = 1'b0; en = 0; j = 0; pat_ld = 0; overlap = 1; pat_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Idle: en/j ignored.
      wv = '0;
      for (int i = 0; i < 4; i++) begin step(1'b1, i[0], 1'b0, '0, d); wv[i] = d; end
      chk("idle_w", {24'd0, wv}, 32'd0);
      chk("idle_armed", {31'd0, armed}, 32'd0);

      // Basic overlapping match: hits on bits 5 and 8.
      overlap = 1; load(5'b10010);
      chk("armed_after_load", {31'd0, armed}, 32'd1);
      stream(8'b10010010, 8, wv);
      chk("basic_ovl_w", {24'd0, wv}, 32'b1001_0000);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      chk("basic_ovl_cnt", {30'd0, cnt}, 32'd2);
`else
      chk("basic_ovl_cnt", {30'd0, cnt}, 32'd0);
`endif

      // Non-overlapping: only bit 5 matches.
      overlap = 0; load(5'b10010);
      stream(8'b10010010, 8, wv);
      chk("nonovl_w", {24'd0, wv}, 32'b0001_0000);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      chk("nonovl_cnt", {30'd0, cnt}, 32'd1);
`endif

      // Enable gaps: bubbles with random j never match or shift.
      overlap = 1; load(5'b10010);
      wv = '0; bub = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, (i == 0 || i == 3), 1'b0, '0, d); wv[i] = d;
         step(1'b0, 1'($urandom_range(1)), 1'b0, '0, d); bub |= d;
      end
      chk("gap_w", {24'd0, wv}, 32'b0001_0000);
      chk("gap_bubble_w", {31'd0, bub}, 32'd0);

      // Reload priority over a would-be match.
      load(5'b10010);
      stream(8'b00001001, 4, wv);
      step(1'b1, 1'b0, 1'b1, 5'b11111, d);
      chk("reload_w", {31'd0, d}, 32'd0);
      stream(8'b00011111, 5, wv);
      chk("reload_ones_w", {24'd0, wv}, 32'b0001_0000);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      chk("reload_cnt", {30'd0, cnt}, 32'd1);
`endif

      // All-zeros pattern with overlap: hits on bits 5..8, counter saturates.
      overlap = 1; load(5'b00000);
      stream(8'b00000000, 8, wv);
      chk("zeros_w", {24'd0, wv}, 32'b1111_0000);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      chk("sat_cnt", {30'd0, cnt}, 32'd3);
`else
      chk("sat_cnt", {30'd0, cnt}, 32'd0);
`endif

      // Mid-stream asynchronous reset.
      stream(8'b00000000, 2, wv);
      rst = 1'b0; #1;
      chk("rst_w", {31'd0, w}, 32'd0);
      chk("rst_armed", {31'd0, armed}, 32'd0);
      chk("rst_cnt", {30'd0, cnt}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Randomized traffic; the per-cycle compare process checks every cycle.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) overlap = ~overlap;
         rst = ($urandom_range(199) != 0);
         step(($urandom_range(3) != 0), 1'($urandom_range(1)),
              ($urandom_range(39) == 0),
              ($urandom_range(1) ? 5'b10101 : PW'($urandom)), d);
         rst = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector: next generation of the team's fixed-pattern Mealy sequence detector.
- The pattern is runtime-loadable and PW bits wide; the old detector is hardwired to one 5-bit sequence.
- Adds a qualifying enable on the input stream, selectable overlapping/non-overlapping matching, and an optional saturating match counter.
- Sits between a serial bit source and control logic that consumes the single-cycle match flag.

Parameters:
- PW, default 5: pattern length in bits. Must be >= 2.
- CW, default 8: match counter width.

Ports:
- clk  input  1: clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- en  input  1: stream qualifier; j is sampled only when en=1.
- j  input  1: serial data bit.
- pat_ld  input  1: load strobe for pat_in.
- pat_in  input  PW: pattern. MSB is the first bit received.
- overlap  input  1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- w  output  1: Mealy match flag, combinational from state and inputs.
- armed  output  1: high while in RUN.
- cnt  output  CW: match count. Tied to 0 when the optional feature is absent.

Behaviour:
- Registers: state (IDLE, RUN), pat[PW-1:0], hist[PW-2:0], fill (0..PW-1 saturating), cnt.
- Reset (rst=0, asynchronous): state=IDLE, pat=0, hist=0, fill=0, cnt=0, armed=0, w=0. Takes effect immediately, including mid-stream.
- IDLE:
  - en and j are ignored; w=0.
  - pat_ld=1 at a clock edge: pat<=pat_in, hist<=0, fill<=0, cnt<=0, state<=RUN.
- RUN, pat_ld=1:
  - Same load action as in IDLE; state stays RUN.
  - pat_ld has priority over en in the same cycle: no shift, no match, w=0.
- RUN, pat_ld=0, en=0: all registers hold; w=0.
- RUN, pat_ld=0, en=1:
  - cand = {hist, j} (PW bits).
  - w = (fill == PW-1) && (cand == pat). Combinational, same cycle as the final bit, no latency.
  - Clock edge when w=1 and overlap=1: hist<=cand[PW-2:0], fill stays PW-1.
  - Clock edge when w=1 and overlap=0: hist<=0, fill<=0. The next match needs PW fresh bits.
  - Clock edge otherwise: hist<=cand[PW-2:0], fill<=min(fill+1, PW-1).
- overlap is sampled combinationally each cycle. Changing it mid-stream affects only the next match event.
- There is no exit from RUN except reset. Reloading a pattern restarts the history.
- The all-zeros pattern is legal and matches after PW zeros.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined:
  - cnt increments by 1 on each clock edge where w=1.
  - Saturates at 2^CW-1 with no wrap.
  - Cleared by reset and by pat_ld.
- Undefined:
  - No counter register is synthesised; cnt is a constant 0.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst=0 mid-run, then release. Expect w=0, armed=0, cnt=0. With en=1 and j toggling in IDLE, w stays 0.
- Basic match, overlap=1: PW=5, load pat=5'b10010, stream 1,0,0,1,0,0,1,0 with en=1. Expect w=1 in the same cycle as bit 5 and bit 8 only; cnt=2 (feature on).
- Non-overlap: same stream with overlap=0. Expect w=1 at bit 5 only; bit 8 gives no match; cnt=1.
- Enable gaps: stream 1,0,0,1,0 with en=0 bubbles inserted between bits; j toggles randomly during bubbles. Expect a single w=1 on the final qualified bit and w=0 in every bubble.
- Reload priority: in RUN after bits 1,0,0,1, drive pat_ld=1 with en=1 and j=0, pat_in=5'b11111. Expect w=0 that cycle and history cleared. Then five 1s give w=1 on the fifth only, and cnt restarts from 0.
- Saturation (feature on, CW=2): pat=5'b00000, overlap=1, stream eight 0s. Expect w=1 on bits 5..8 and cnt to stick at 3. With the macro undefined, cnt=0 throughout.
